// File: rtl/cisr_row_decoder.sv
// ----------------------------------------------------------------------------
// cisr_row_decoder
//
// Assigns matrix row IDs to the NUM_CH channels of a CISR sparse
// matrix-vector engine and tags every nonzero a channel consumes with the row
// it belongs to.
//
// Each channel pops a row length from its row-length FIFO whenever it needs a
// new row. It can need one either because it is idle, or because it is
// consuming the last element of its current row in this cycle (back-to-back).
// Row IDs are handed out in ascending channel order from one global counter.
//
// Ports
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset
//   spmv_init      synchronous clear, same effect as reset
//   num_rows       total matrix rows, sampled on start
//   start          one-cycle pulse that begins decoding (ignored while busy)
//   row_len_in     head of each channel's row-length FIFO, channel c at
//                  [c*DATA_W +: DATA_W]
//   row_len_valid  per-channel FIFO non-empty
//   row_len_pop    per-channel FIFO pop (combinational)
//   elem_adv       per-channel: one nonzero consumed this cycle
//   row_id_out     registered row ID of each channel's last advanced element,
//                  channel c at [c*DIM_W +: DIM_W]
//   busy           high from start until done
//   dec_done       one-cycle completion pulse
//   adv_err        sticky per-channel flag: elem_adv with no active row
// ----------------------------------------------------------------------------
module cisr_row_decoder #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 32,
    parameter int DIM_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spmv_init,
    input  logic [DIM_W:0]           num_rows,
    input  logic                     start,
    input  logic [NUM_CH*DATA_W-1:0] row_len_in,
    input  logic [NUM_CH-1:0]        row_len_valid,
    output logic [NUM_CH-1:0]        row_len_pop,
    input  logic [NUM_CH-1:0]        elem_adv,
    output logic [NUM_CH*DIM_W-1:0]  row_id_out,
    output logic                     busy,
    output logic                     dec_done,
    output logic [NUM_CH-1:0]        adv_err
);

    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_ACTIVE = 1'b1;
    localparam logic [DATA_W-1:0] REM_ZERO  = '0;
    localparam logic [DATA_W-1:0] REM_ONE   = DATA_W'(1);
    localparam logic [DIM_W:0]    CNT_ONE   = (DIM_W+1)'(1);

    // Per-channel state
    logic [NUM_CH-1:0]              r_state;
    logic [NUM_CH-1:0][DATA_W-1:0]  r_rem;
    logic [NUM_CH-1:0][DIM_W-1:0]   r_row;
    logic [NUM_CH-1:0][DIM_W-1:0]   r_row_id_out;
    logic [NUM_CH-1:0]              r_adv_err;

    // Global state
    logic                           r_busy;
    logic                           r_dec_done;
    logic [DIM_W:0]                 r_next_row;
    logic [DIM_W:0]                 r_num_rows;

    logic                           w_clear;
    logic [DIM_W:0]                 w_rows_left;
    logic [NUM_CH-1:0]              w_req;
    logic [NUM_CH-1:0]              w_gnt;
    logic [NUM_CH-1:0][DIM_W-1:0]   w_id;
    logic [DIM_W:0]                 w_gcnt;
    logic                           w_all_idle;
    logic                           w_done_cond;

    assign w_clear     = !rst_n || spmv_init;
    // next_row never passes num_rows, so this cannot underflow.
    assign w_rows_left = r_num_rows - r_next_row;

    // Grant in ascending channel order. The running grant count is also the
    // row offset for the channel being examined; once the rows left are used
    // up every higher requester simply waits.
    always_comb begin
        logic [DIM_W:0] v_cnt;
        v_cnt      = '0;
        w_req      = '0;
        w_gnt      = '0;
        w_id       = '0;
        w_all_idle = 1'b1;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (r_state[c] != ST_IDLE) begin
                w_all_idle = 1'b0;
            end
            w_req[c] = r_busy && row_len_valid[c] && (r_next_row < r_num_rows) &&
                       ((r_state[c] == ST_IDLE) ||
                        ((r_state[c] == ST_ACTIVE) && (r_rem[c] == REM_ONE) && elem_adv[c]));
            if (w_req[c] && (v_cnt < w_rows_left)) begin
                w_gnt[c] = 1'b1;
                w_id[c]  = r_next_row[DIM_W-1:0] + v_cnt[DIM_W-1:0];
                v_cnt    = v_cnt + CNT_ONE;
            end
        end
        w_gcnt = v_cnt;
    end

    assign w_done_cond = r_busy && (r_next_row == r_num_rows) && w_all_idle;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state      <= '0;
            r_rem        <= '0;
            r_row        <= '0;
            r_row_id_out <= '0;
            r_adv_err    <= '0;
            r_busy       <= 1'b0;
            r_dec_done   <= 1'b0;
            r_next_row   <= '0;
            r_num_rows   <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (elem_adv[c]) begin
                    if (r_state[c] == ST_ACTIVE) begin
                        r_row_id_out[c] <= r_row[c];
                        r_rem[c]        <= r_rem[c] - REM_ONE;
                        if (r_rem[c] == REM_ONE) begin
                            r_state[c] <= ST_IDLE;
                        end
                    end else begin
                        r_adv_err[c] <= 1'b1;
                    end
                end
                // A grant overrides the decrement above: on a back-to-back
                // grant the last element of the old row is still tagged with
                // the old ID while the new row is loaded.
                if (w_gnt[c]) begin
                    r_rem[c] <= row_len_in[c*DATA_W +: DATA_W];
                    if (row_len_in[c*DATA_W +: DATA_W] != REM_ZERO) begin
                        r_state[c] <= ST_ACTIVE;
                        r_row[c]   <= w_id[c];
                    end else begin
                        r_state[c] <= ST_IDLE;
                    end
                end
            end

            r_dec_done <= w_done_cond;
            if (w_done_cond) begin
                r_busy <= 1'b0;
            end else if (!r_busy) begin
                if (start) begin
                    r_busy     <= 1'b1;
                    r_next_row <= '0;
                    r_num_rows <= num_rows;
                end
            end else begin
                r_next_row <= r_next_row + w_gcnt;
            end
        end
    end

    assign row_len_pop = w_clear ? '0 : w_gnt;
    assign row_id_out  = r_row_id_out;
    assign busy        = r_busy;
    assign dec_done    = r_dec_done;
    assign adv_err     = r_adv_err;

endmodule

// File: doc/cisr_row_decoder.md
CISR_ROW_DECODER -- requirements
Module: cisr_row_decoder

Interface
REQ-001 SHALL take parameters: NUM_CH, default 16, channel count; DATA_W, default 32, row-length width; DIM_W, default 10, row-index width (MAX_DIM_LEN 1024).
REQ-002 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port spmv_init, input, 1, synchronous clear with the same effect as reset.
REQ-005 SHALL have port num_rows, input, DIM_W+1, total matrix rows; sampled on start.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that begins decoding.
REQ-007 SHALL have port row_len_in, input, NUM_CH*DATA_W, head of each channel row-length FIFO; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-008 SHALL have port row_len_valid, input, NUM_CH, per-channel row-length FIFO non-empty.
REQ-009 SHALL have port row_len_pop, output, NUM_CH, per-channel FIFO pop; combinational.
REQ-010 SHALL have port elem_adv, input, NUM_CH, channel consumed one nonzero this cycle (fetch not stalled).
REQ-011 SHALL have port row_id_out, output, NUM_CH*DIM_W, registered row ID of each channel's last advanced element.
REQ-012 SHALL have port busy, output, 1, high from start until done.
REQ-013 SHALL have port dec_done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port adv_err, output, NUM_CH, sticky flag: elem_adv arrived with no active row.

Function
REQ-015 SHALL keep per-channel state IDLE or ACTIVE, a remaining-count (DATA_W), and a current row ID (DIM_W).
REQ-016 SHALL keep a global next_row counter (DIM_W+1); start loads 0 and latches num_rows, and start while busy is ignored.
REQ-017 SHALL define a channel as requesting when busy, row_len_valid[c] is high, next_row < num_rows, and the channel is either IDLE, or ACTIVE with remaining==1 and elem_adv[c] high (back-to-back).
REQ-018 SHALL grant requesting channels in ascending index order, channel c receiving next_row + (number of lower requesting channels), limited to the rows left; ungranted channels wait.
REQ-019 SHALL assert row_len_pop[c] only for granted channels, and SHALL advance next_row by the grant count.
REQ-020 SHALL, on grant with len>0, load remaining=len and row ID=assigned value, and set ACTIVE.
REQ-021 SHALL, on grant with len==0, consume the ID without emitting any element and remain or become IDLE, so an empty row costs one cycle.
REQ-022 SHALL, on elem_adv[c] in ACTIVE, register the current row ID onto row_id_out[c] on the next edge (1-cycle latency, aligned to the channel fetch stage) and decrement remaining.
REQ-023 SHALL go IDLE when remaining reaches 0 unless back-to-back granted.
REQ-024 SHALL hold row_id_out[c] when there is no advance.
REQ-025 SHALL, on elem_adv[c] while IDLE, set adv_err[c], leave row_id_out[c] unchanged, and change no other state.
REQ-026 SHALL pulse dec_done one cycle after next_row==num_rows with all channels IDLE, then drop busy.
REQ-027 SHALL, when start has num_rows==0, pulse dec_done on the next cycle.
REQ-028 SHALL treat arithmetic as unsigned without wrap; next_row saturates at num_rows.

Reset
REQ-029 SHALL, on rst_n low or spmv_init high at a clock edge, set all channels IDLE, remaining=0, row_id_out=0, next_row=0, busy=0, dec_done=0, and adv_err=0.
REQ-030 SHALL assert row_len_pop=0 while reset is active.
REQ-031 SHALL abandon any in-flight operation on reset, with no dec_done pulse.

Verification
REQ-032 SHALL cover single-channel allocation: NUM_CH=4, num_rows=3, ch0 lengths 2,1,3, elem_adv continuous -> row_id_out[0] sequence 0,0,1,2,2,2 with no bubbles; dec_done 1 cycle after the last advance.
REQ-033 SHALL cover simultaneous grant: ch0, ch2, ch3 IDLE and valid in the same cycle with next_row=5 -> IDs 5, 6, 7 respectively; next_row=8.
REQ-034 SHALL cover empty row: ch1 lengths 0,2 -> row 0 skipped, both elements tagged 1, one pop per cycle.
REQ-035 SHALL cover the row limit: num_rows=2, four channels valid -> only ch0 and ch1 popped; the others never pop; dec_done after both finish.
REQ-036 SHALL cover the error and reset case: elem_adv[3] while IDLE -> adv_err[3]=1 sticky; spmv_init mid-run -> all outputs 0 the next cycle and no dec_done.
